// File: rtl/exe_lsu_if.sv
// Memory-side request/response bus of the load/store unit.
// The LSU drives the master modport; the memory system drives the slave modport.
interface exe_lsu_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  localparam int unsigned LANES = DATA_W / 8;

  logic              req;
  logic              req_wr;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [LANES-1:0]  req_wstrb;
  logic [DATA_W-1:0] req_wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, req_wr, req_size, req_addr, req_wstrb, req_wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, req_wr, req_size, req_addr, req_wstrb, req_wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/exe_lsu.sv
// Execute-stage load/store request unit: handshaked memory requests with up to MAX_OUTST
// outstanding transactions, byte strobes, misalignment traps and extended load returns.
module exe_lsu #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_sign,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              flush,
  exe_lsu_if.master         mem,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ale_valid,
  output logic [ADDR_W-1:0] ale_badv
);
  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned OFS_W = $clog2(LANES);
  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {StIdle, StReq} state_e;

  typedef struct packed {
    logic             is_load;
    logic [1:0]       size;
    logic             sign;
    logic [OFS_W-1:0] offset;
    logic             discard;
  } entry_t;

  state_e            state;
  logic [2:0]        cnt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  entry_t            fifo [MAX_OUTST];
  logic              held_sign, held_discard;

  logic              accept, misaligned, push, pop, bypass, deliver;
  entry_t            push_entry, pop_entry;
  logic [LANES-1:0]  strb;
  logic [DATA_W-1:0] rep_data, shifted, ext_data;
  int unsigned       off, nbytes, nbits;
  logic              msb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready = (state == StIdle) && (cnt < 3'(MAX_OUTST)) && !flush;
  assign accept   = in_valid && in_ready;

  // A dword op on a 32-bit datapath can never be aligned.
  always_comb begin
    unique case (in_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = |in_addr[1:0];
      default: misaligned = (DATA_W != 64) || (|in_addr[2:0]);
    endcase
  end

  always_comb begin
    off      = int'(in_addr[OFS_W-1:0]);
    nbytes   = 1 << in_size;
    strb     = '0;
    rep_data = '0;
    for (int j = 0; j < LANES; j++) begin
      strb[j] = in_store && (j >= off) && (j < off + nbytes);
      unique case (in_size)
        2'b00:   rep_data[j*8 +: 8] = in_wdata[7:0];
        2'b01:   rep_data[j*8 +: 8] = in_wdata[(j%2)*8 +: 8];
        2'b10:   rep_data[j*8 +: 8] = in_wdata[(j%4)*8 +: 8];
        default: rep_data[j*8 +: 8] = in_wdata[(j%8)*8 +: 8];
      endcase
    end
  end

  // A response arriving with the addr_ok of an empty FIFO consumes the entry being pushed.
  assign push   = (state == StReq) && mem.addr_ok;
  assign bypass = mem.data_ok && push && (cnt == 3'd0);
  assign pop    = mem.data_ok && ((cnt != 3'd0) || push);

  always_comb begin
    push_entry.is_load = !mem.req_wr;
    push_entry.size    = mem.req_size;
    push_entry.sign    = held_sign;
    push_entry.offset  = mem.req_addr[OFS_W-1:0];
    push_entry.discard = held_discard || flush;
    pop_entry          = bypass ? push_entry : fifo[rd_ptr];
  end

  assign deliver = pop && pop_entry.is_load && !pop_entry.discard && !flush;

  always_comb begin
    shifted = mem.rdata >> {pop_entry.offset, 3'b000};
    unique case (pop_entry.size)
      2'b00:   begin nbits = 8;  msb = shifted[7];        end
      2'b01:   begin nbits = 16; msb = shifted[15];       end
      2'b10:   begin nbits = 32; msb = shifted[31];       end
      default: begin nbits = 64; msb = shifted[DATA_W-1]; end
    endcase
    ext_data = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ext_data[b] = (b < nbits) ? shifted[b] : (pop_entry.sign & msb);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= StIdle;
      cnt           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      held_sign     <= 1'b0;
      held_discard  <= 1'b0;
      mem.req       <= 1'b0;
      mem.req_wr    <= 1'b0;
      mem.req_size  <= '0;
      mem.req_addr  <= '0;
      mem.req_wstrb <= '0;
      mem.req_wdata <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      ale_valid     <= 1'b0;
      ale_badv      <= '0;
      for (int i = 0; i < MAX_OUTST; i++) fifo[i] <= '0;
    end else begin
      ale_valid <= accept && misaligned;
      if (accept && misaligned) ale_badv <= in_addr;
      rsp_valid <= deliver;
      if (deliver) rsp_data <= ext_data;

      if (flush) begin
        for (int i = 0; i < MAX_OUTST; i++) fifo[i].discard <= 1'b1;
      end
      if (push && !bypass) begin
        fifo[wr_ptr] <= push_entry;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (pop && !bypass) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop) cnt <= cnt + 3'd1;
      else if (pop && !push) cnt <= cnt - 3'd1;

      unique case (state)
        StIdle: begin
          if (accept && !misaligned) begin
            state         <= StReq;
            mem.req       <= 1'b1;
            mem.req_wr    <= in_store;
            mem.req_size  <= in_size;
            mem.req_addr  <= in_addr;
            mem.req_wstrb <= strb;
            mem.req_wdata <= rep_data;
            held_sign     <= in_sign;
            held_discard  <= 1'b0;
          end
        end
        StReq: begin
          if (flush) held_discard <= 1'b1;
          if (mem.addr_ok) begin
            state   <= StIdle;
            mem.req <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  a_no_spurious_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(mem.data_ok && (cnt == 3'd0) && !push));
endmodule

// File: doc/exe_lsu.md
# exe_lsu

Parametrised load/store request unit for the execute stage. It replaces the single-cycle, always-ready data SRAM port with a handshaked request/response memory interface that supports multiple outstanding transactions. It generates byte strobes and lane-replicated store data, detects misaligned addresses, and returns sign- or zero-extended load data to the memory stage. It supports 32- or 64-bit datapaths and carries flush/discard semantics for outstanding requests.

## Interface
- DATA_W, 32, datapath width; legal values are 32 and 64. LANES = DATA_W/8, OFS_W = log2(LANES).
- ADDR_W, 32, address width.
- MAX_OUTST, 2, maximum number of accepted-but-unanswered requests (1..4).
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute stage presents a memory op
- in_ready  out  1  unit accepts the op this cycle
- in_store  in  1  1 = store, 0 = load
- in_size  in  2  00 byte, 01 half, 10 word, 11 dword
- in_sign  in  1  load result is sign-extended
- in_addr  in  ADDR_W  effective address
- in_wdata  in  DATA_W  store source register; the low bytes are used
- flush  in  1  discard all in-flight loads
- req  out  1  memory request valid
- req_wr  out  1  write request
- req_size  out  2  copy of in_size
- req_addr  out  ADDR_W  full byte address
- req_wstrb  out  LANES  byte enables; all zero for loads
- req_wdata  out  DATA_W  lane-replicated store data
- addr_ok  in  1  request accepted
- data_ok  in  1  response for the oldest outstanding request
- rdata  in  DATA_W  load data, valid with data_ok
- rsp_valid  out  1  one-cycle pulse; load result is valid
- rsp_data  out  DATA_W  extended load result
- ale_valid  out  1  one-cycle pulse on a misaligned op
- ale_badv  out  ADDR_W  faulting address

## Operation
- **States.**
  - IDLE: no request is held.
  - REQ: registered request driven on req.
  - IDLE→REQ on an accept of an aligned op. REQ→IDLE on addr_ok.
- **Accept.** in_ready = (state==IDLE) && (cnt < MAX_OUTST) && !flush. An accept is in_valid && in_ready.
- **Alignment.**
  - Byte is always aligned.
  - Half requires addr[0]==0. Word requires addr[1:0]==0. Dword requires addr[2:0]==0.
  - in_size==11 with DATA_W==32 is treated as misaligned.
  - A misaligned accept issues no request and stays in IDLE. The next cycle has ale_valid=1 and ale_badv=in_addr.
- **Strobes.**
  - nbytes = 1 << in_size.
  - wstrb = ((1<<nbytes)-1) << addr[OFS_W-1:0] for stores, 0 for loads.
  - wdata = the low nbytes bytes of in_wdata, replicated across all lanes.
- **Pending FIFO.**
  - Depth is MAX_OUTST. Each entry holds {is_load, size, sign, offset, discard}.
  - An entry is pushed on the REQ cycle that has addr_ok, and popped on data_ok.
  - cnt: +1 on push, −1 on pop, unchanged when both happen in the same cycle.
  - data_ok with cnt==0 (and no same-cycle push) is a protocol error. It is ignored and covered by an assertion.
- **Load return.**
  - shifted = rdata >> (offset*8). The low nbytes bytes are then sign- or zero-extended to DATA_W per the sign bit.
  - For a load entry with discard==0, rsp_valid=1 the cycle after data_ok, with rsp_data = the extended value.
  - Store entries pop silently.
- **Flush.**
  - Sets discard on every FIFO entry, and on the request held in REQ.
  - The held request still completes: req stays high until addr_ok, because a request cannot be withdrawn.
  - Discarded loads pop on data_ok with no rsp_valid.

## Timing
- Reset values: req=0, req_wr=0, req_addr=0, req_wstrb=0, req_wdata=0, req_size=0, rsp_valid=0, rsp_data=0, ale_valid=0, ale_badv=0. State=IDLE, cnt=0, FIFO empty.
- Reset during REQ drops req on the next cycle. The FIFO is cleared, and later data_ok pulses are ignored.
- Accept at edge N: req=1 during cycle N+1. The request is held stable until and including the addr_ok cycle, and req=0 the cycle after.
- Back-to-back ops: the earliest next accept is the cycle after the addr_ok cycle. Peak issue rate is one request per two cycles.
- data_ok may arrive in the same cycle as addr_ok for the same request only if the FIFO bypasses the push.
- Load latency from data_ok to rsp_valid is exactly 1 cycle. There is no backpressure on rsp_valid.
- ale_valid fires 1 cycle after the misaligned accept.
- When cnt==MAX_OUTST, in_ready stays 0 until a pop. in_ready rises in the cycle after data_ok.

## Test plan
- **Store byte (DATA_W=32).** Store byte at 0x1003 with in_wdata=0x000000A5 -> req_wstrb=1000, req_wdata=0xA5A5A5A5, req_wr=1; req held over 3 cycles of addr_ok=0 with stable fields.
- **Load half, signed.** Load half, signed, at 0x2002; data_ok with rdata=0x8001_1234 -> rsp_valid next cycle, rsp_data=0xFFFF8001. The same load with unsigned -> 0x00008001.
- **Misaligned.** Word op at 0x3001 -> no req; ale_valid=1, ale_badv=0x3001 one cycle after the accept. DATA_W=32 with size 11 at 0x0 -> ale_valid=1.
- **Outstanding limit (MAX_OUTST=2).** Two loads accepted and addr_ok'd with no data_ok -> in_ready=0. One data_ok -> in_ready=1 the next cycle. Responses come back in order with the correct per-entry extension.
- **Flush.** Flush with one load in FIFO and one in REQ -> the REQ request still completes; both data_ok pulses produce no rsp_valid; cnt returns to 0.
- **DATA_W=64.** Dword load at 0x...8 -> rsp_data=rdata. Store word at offset 4 -> req_wstrb=0xF0 and wdata replicated in both 32-bit halves.
